// File: rtl/flash_prim_cmd_ctrl.sv
// Flash primitive command controller (initiator side).
// Accepts one host command at a time (read / program / erase), drives the
// packed flash request word, tracks the primitive's ack/done handshake and
// returns read data plus error status on a valid/ready response channel.
// A cycle budget aborts any transaction the primitive never completes.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   cmd_valid_i/ready_o  host command handshake (ready only in IDLE)
//   cmd_op_i             0 read, 1 program, 2 erase, 3 illegal
//   cmd_addr_i           flash word address
//   cmd_wdata_i          program data
//   flash_req_o          {wdata, addr, erase, prog, rd}
//   flash_rsp_i          packed primitive response (ack, done, rd_err, rdata)
//   rsp_valid_o/ready_i  host response handshake
//   rsp_rdata_o          captured read data (zero for program / erase)
//   rsp_err_o            [0] read error, [1] timeout or illegal op
module flash_prim_cmd_ctrl #(
  parameter int unsigned AddrW         = 16,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_op_i,
  input  logic [AddrW-1:0]   cmd_addr_i,
  input  logic [63:0]        cmd_wdata_i,
  output logic [AddrW+66:0]  flash_req_o,
  input  logic [119:0]       flash_rsp_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [63:0]        rsp_rdata_o,
  output logic [1:0]         rsp_err_o
);

  localparam int unsigned ReqW    = AddrW + 67;
  localparam int unsigned DataW   = 64;
  localparam int unsigned CntW    = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  localparam logic [1:0] OpRead    = 2'd0;
  localparam logic [1:0] OpProg    = 2'd1;
  localparam logic [1:0] OpErase   = 2'd2;
  localparam logic [1:0] OpIllegal = 2'd3;

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrAbort   = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWaitDone,
    StResp
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [ReqW-1:0]    req_q, req_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               valid_q, valid_d;
  logic [DataW-1:0]   rdata_q, rdata_d;
  logic [1:0]         err_q, err_d;

  // Response word fields; the remaining bits carry nothing for this block.
  logic               rsp_ack;
  logic               rsp_done;
  logic               rsp_rd_err;
  logic [DataW-1:0]   rsp_rdata;
  logic               unused_rsp_bits;

  assign rsp_ack         = flash_rsp_i[11];
  assign rsp_done        = flash_rsp_i[12];
  assign rsp_rd_err      = flash_rsp_i[13];
  assign rsp_rdata       = flash_rsp_i[77:14];
  assign unused_rsp_bits = ^{flash_rsp_i[119:78], flash_rsp_i[10:0]};

  // One-hot operation strobe for a new command.
  logic [2:0] cmd_strobe;
  always_comb begin
    cmd_strobe = 3'b000;
    unique case (cmd_op_i)
      OpRead:  cmd_strobe = 3'b001;
      OpProg:  cmd_strobe = 3'b010;
      OpErase: cmd_strobe = 3'b100;
      default: cmd_strobe = 3'b000;
    endcase
  end

  logic timeout;
  assign timeout = (cnt_q == CntLast);

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    valid_d     = valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cmd_ready_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          op_d  = cmd_op_i;
          cnt_d = '0;
          if (cmd_op_i == OpIllegal) begin
            state_d = StResp;
            valid_d = 1'b1;
            rdata_d = '0;
            err_d   = ErrAbort;
          end else begin
            state_d = StReq;
            req_d   = {cmd_wdata_i, cmd_addr_i, cmd_strobe};
          end
        end
      end

      StReq: begin
        cnt_d = cnt_q + CntW'(1);
        if (rsp_ack && rsp_done) begin
          // Completion in the first accepted cycle; completion beats timeout.
          state_d = StResp;
          req_d   = '0;
          valid_d = 1'b1;
          rdata_d = (op_q == OpRead) ? rsp_rdata : '0;
          err_d   = {1'b0, (op_q == OpRead) && rsp_rd_err};
        end else if (timeout) begin
          state_d = StResp;
          req_d   = '0;
          valid_d = 1'b1;
          rdata_d = '0;
          err_d   = ErrAbort;
        end else if (rsp_ack) begin
          state_d = StWaitDone;
          req_d   = '0;
        end
      end

      StWaitDone: begin
        cnt_d = cnt_q + CntW'(1);
        if (rsp_done) begin
          state_d = StResp;
          valid_d = 1'b1;
          rdata_d = (op_q == OpRead) ? rsp_rdata : '0;
          err_d   = {1'b0, (op_q == OpRead) && rsp_rd_err};
        end else if (timeout) begin
          state_d = StResp;
          valid_d = 1'b1;
          rdata_d = '0;
          err_d   = ErrAbort;
        end
      end

      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
          valid_d = 1'b0;
          rdata_d = '0;
          err_d   = ErrNone;
        end
      end

      default: begin
        state_d = StIdle;
        req_d   = '0;
        valid_d = 1'b0;
        rdata_d = '0;
        err_d   = ErrNone;
      end
    endcase

    // Ready is registered, so it reflects the state being entered.
    cmd_ready_d = (state_d == StIdle);
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      op_q        <= OpRead;
      cnt_q       <= '0;
      req_q       <= '0;
      cmd_ready_q <= 1'b1;
      valid_q     <= 1'b0;
      rdata_q     <= '0;
      err_q       <= ErrNone;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      cmd_ready_q <= cmd_ready_d;
      valid_q     <= valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign flash_req_o = req_q;
  assign rsp_valid_o = valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_flash_prim_cmd_ctrl.sv
// Self-checking bench for flash_prim_cmd_ctrl: directed vector table,
// randomized transactions against a transaction-level reference model,
// and hand-written reset / back-pressure sequences.
module tb_flash_prim_cmd_ctrl;

  localparam int unsigned AW = 16;
  localparam int unsigned TO = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [AW-1:0]     cmd_addr;
  logic [63:0]       cmd_wdata;
  logic [AW+66:0]    flash_req;
  logic [119:0]      flash_rsp;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [63:0]       rsp_rdata;
  logic [1:0]        rsp_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  flash_prim_cmd_ctrl #(.AddrW(AW), .TimeoutCycles(TO)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_addr_i  (cmd_addr),
    .cmd_wdata_i (cmd_wdata),
    .flash_req_o (flash_req),
    .flash_rsp_i (flash_rsp),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err)
  );

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [63:0] wdata;
    int          ack_at;   // REQ-relative cycle of the ack pulse, 0 = never
    int          done_at;  // cycle of the done pulse, 0 = never
    logic [63:0] rd;
    logic        rderr;
    int          hold;     // cycles of response back-pressure
    int          lat;      // expected first cycle with rsp_valid
    int          reqc;     // expected cycles with a request bit high
    logic [63:0] erd;
    logic [1:0]  eerr;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [119:0] mk_rsp(input bit ack, input bit done,
                                          input logic [63:0] rd, input bit rderr);
    logic [119:0] r;
    r[31:0]   = $urandom;
    r[63:32]  = $urandom;
    r[95:64]  = $urandom;
    r[119:96] = 24'($urandom);
    r[11]     = ack;
    r[12]     = done;
    r[13]     = rderr;
    r[77:14]  = rd;
    return r;
  endfunction

  // Transaction-level reference: which cycle ends the transaction and how.
  task automatic model_txn(input logic [1:0] op, input int ack_at, input int done_at,
                           input logic [63:0] rd, input logic rderr,
                           output int lat, output int reqc,
                           output logic [63:0] erd, output logic [1:0] eerr);
    bit ack_ok, done_ok;
    if (op == 2'd3) begin
      lat = 1; reqc = 0; erd = '0; eerr = 2'b10;
    end else begin
      ack_ok  = (ack_at != 0) && (ack_at <= int'(TO));
      done_ok = ack_ok && (done_at != 0) && (done_at >= ack_at) && (done_at <= int'(TO));
      reqc    = ack_ok ? ack_at : int'(TO);
      lat     = (done_ok ? done_at : int'(TO)) + 1;
      erd     = (done_ok && op == 2'd0) ? rd : 64'd0;
      eerr    = !done_ok ? 2'b10 : {1'b0, (op == 2'd0) ? rderr : 1'b0};
    end
  endtask

  // Drives one command and its primitive behaviour; called on a negedge.
  task automatic run_txn(input vec_t v, input string tag);
    logic [2:0]      bits;
    logic [AW+66:0]  exp_word;
    int              lat, reqc;
    bit              req_bad, hold_bad;
    bits = (v.op == 2'd0) ? 3'b001 : (v.op == 2'd1) ? 3'b010 :
           (v.op == 2'd2) ? 3'b100 : 3'b000;
    exp_word = {v.wdata, v.addr, bits};

    check({tag, " cmd_ready_idle"}, 96'(cmd_ready), 96'(1));
    cmd_valid = 1'b1; cmd_op = v.op; cmd_addr = v.addr; cmd_wdata = v.wdata;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_addr = 16'($urandom); cmd_wdata = rand64();

    lat = 0; reqc = 0; req_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      if (rsp_valid) begin lat = k; break; end
      if (flash_req[2:0] != 3'b000) begin
        if (flash_req !== exp_word || reqc != k - 1) req_bad = 1;
        reqc++;
      end else if (flash_req !== '0) begin
        req_bad = 1;
      end
      flash_rsp = mk_rsp(k == v.ack_at, k == v.done_at,
                         (k == v.done_at) ? v.rd : rand64(),
                         (k == v.done_at) ? v.rderr : 1'($urandom));
      @(posedge clk); @(negedge clk);
    end
    check({tag, " latency"},   96'(lat),  96'(v.lat));
    check({tag, " req_cycles"}, 96'(reqc), 96'(v.reqc));
    check({tag, " req_word"},  96'(req_bad), 96'(0));
    check({tag, " rdata"},     96'(rsp_rdata), 96'(v.erd));
    check({tag, " err"},       96'(rsp_err),   96'(v.eerr));

    // Back-pressure with stray primitive traffic: everything must hold.
    hold_bad = 0;
    for (int h = 0; h < v.hold; h++) begin
      flash_rsp = mk_rsp(1'($urandom), 1'b1, rand64(), 1'($urandom));
      @(posedge clk); @(negedge clk);
      if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || flash_req !== '0 ||
          rsp_rdata !== v.erd || rsp_err !== v.eerr) hold_bad = 1;
    end
    if (v.hold > 0) check({tag, " hold_stable"}, 96'(hold_bad), 96'(0));

    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, " post_resp"}, {28'd0, rsp_valid, cmd_ready, rsp_err, rsp_rdata},
                               {28'd0, 1'b0, 1'b1, 2'b00, 64'd0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t v;
    bit   bad;

    tbl[0] = '{2'd0, 16'h0123, 64'h0, 2, 5, 64'hDEADBEEF_CAFEF00D, 1'b0, 0,
               6, 2, 64'hDEADBEEF_CAFEF00D, 2'b00};
    tbl[1] = '{2'd1, 16'h0456, {8{8'hA5}}, 1, 1, 64'h1111_2222_3333_4444, 1'b1, 0,
               2, 1, 64'h0, 2'b00};
    tbl[2] = '{2'd0, 16'h0FFF, 64'h0, 1, 3, 64'h01234567_89ABCDEF, 1'b1, 5,
               4, 1, 64'h01234567_89ABCDEF, 2'b01};
    tbl[3] = '{2'd2, 16'h7000, 64'h0, 0, 0, 64'h0, 1'b0, 1,
               9, 8, 64'h0, 2'b10};
    tbl[4] = '{2'd2, 16'h7001, 64'h0, 1, 8, 64'hFFFF_0000_FFFF_0000, 1'b1, 0,
               9, 1, 64'h0, 2'b00};
    tbl[5] = '{2'd3, 16'hBEEF, 64'h55, 1, 1, 64'h0, 1'b0, 2,
               1, 0, 64'h0, 2'b10};
    tbl[6] = '{2'd0, 16'h8001, 64'h0, 8, 8, 64'h0BAD_F00D_1234_5678, 1'b0, 0,
               9, 8, 64'h0BAD_F00D_1234_5678, 2'b00};
    tbl[7] = '{2'd0, 16'h8002, 64'h0, 3, 9, 64'h7777_7777_7777_7777, 1'b0, 0,
               9, 3, 64'h0, 2'b10};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0; cmd_wdata = '0;
    flash_rsp = '0; rsp_ready = 1'b0;
    #23;
    check("reset cmd_ready", 96'(cmd_ready), 96'(1));
    check("reset flash_req", 96'(flash_req), 96'(0));
    check("reset rsp_valid", 96'(rsp_valid), 96'(0));
    check("reset rsp_data",  {30'd0, rsp_err, rsp_rdata}, 96'(0));
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Randomized transactions checked against the reference model.
    for (int i = 0; i < 40; i++) begin
      v.op      = 2'($urandom_range(0, 3));
      v.addr    = 16'($urandom);
      v.wdata   = rand64();
      v.ack_at  = $urandom_range(0, 10);
      v.done_at = (v.ack_at == 0) ? 0 : v.ack_at + $urandom_range(0, 9);
      v.rd      = rand64();
      v.rderr   = 1'($urandom);
      v.hold    = $urandom_range(0, 3);
      model_txn(v.op, v.ack_at, v.done_at, v.rd, v.rderr, v.lat, v.reqc, v.erd, v.eerr);
      run_txn(v, $sformatf("rnd%0d", i));
    end

    // Reset during WAIT_DONE, then a stray done must not produce a response.
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 16'h0042; cmd_wdata = '0;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    flash_rsp = mk_rsp(1'b1, 1'b0, rand64(), 1'b0);
    @(posedge clk); @(negedge clk);
    flash_rsp = mk_rsp(1'b0, 1'b0, rand64(), 1'b0);
    check("midrst in_wait", {29'd0, cmd_ready, rsp_valid, flash_req[2:0], 62'd0},
                            96'(0));
    @(posedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst async", {rsp_valid, cmd_ready, flash_req, 11'd0},
                          {1'b0, 1'b1, 83'd0, 11'd0});
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      flash_rsp = mk_rsp(1'($urandom), 1'b1, rand64(), 1'($urandom));
      @(posedge clk); @(negedge clk);
      if (rsp_valid !== 1'b0 || flash_req !== '0 || cmd_ready !== 1'b1) bad = 1;
    end
    check("midrst stray_done", 96'(bad), 96'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
